// File: rtl/sw_debounce.sv
// Switch-bank conditioner: 2-FF synchronizer per bit followed by a tick-sampled
// stability filter, producing a clean switch word plus per-bit edge pulses.
module sw_debounce #(
  parameter int unsigned      WIDTH      = 32,
  parameter int unsigned      TICK_DIV   = 1000,
  parameter int unsigned      STABLE_CNT = 4,
  parameter logic [WIDTH-1:0] RESET_VAL  = '0
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic [WIDTH-1:0] i_sw_raw,
  output logic [WIDTH-1:0] o_io_sw,
  output logic [WIDTH-1:0] o_sw_rise,
  output logic [WIDTH-1:0] o_sw_fall,
  output logic             o_sw_changed,
  output logic             o_tick
);

  localparam int unsigned PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int unsigned CW = $clog2(STABLE_CNT + 1);
  localparam logic [PW-1:0] PRESC_MAX = PW'(TICK_DIV - 1);
  localparam logic [CW-1:0] CNT_MAX   = CW'(STABLE_CNT - 1);

  logic [WIDTH-1:0]         sync1_q, sync2_q;
  logic [PW-1:0]            presc_q, presc_d;
  logic                     tick_c;
  logic                     tick_q;
  logic [WIDTH-1:0][CW-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0]         sw_q, sw_d;
  logic [WIDTH-1:0]         rise_q, rise_d;
  logic [WIDTH-1:0]         fall_q, fall_d;
  logic                     changed_q, changed_d;

  // Prescaler: tick fires on the last count of each TICK_DIV-cycle window.
  assign tick_c  = (presc_q == PRESC_MAX);
  assign presc_d = tick_c ? '0 : presc_q + PW'(1);

  // Per-bit stability filter; any sample matching the output restarts the count.
  always_comb begin
    cnt_d  = cnt_q;
    sw_d   = sw_q;
    rise_d = '0;
    fall_d = '0;
    if (tick_c) begin
      for (int unsigned i = 0; i < WIDTH; i++) begin
        if (sync2_q[i] == sw_q[i]) begin
          cnt_d[i] = '0;
        end else if (cnt_q[i] == CNT_MAX) begin
          sw_d[i]   = sync2_q[i];
          cnt_d[i]  = '0;
          rise_d[i] = sync2_q[i];
          fall_d[i] = ~sync2_q[i];
        end else begin
          cnt_d[i] = cnt_q[i] + CW'(1);
        end
      end
    end
    changed_d = |(rise_d | fall_d);
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      sync1_q   <= RESET_VAL;
      sync2_q   <= RESET_VAL;
      presc_q   <= '0;
      tick_q    <= 1'b0;
      cnt_q     <= '0;
      sw_q      <= RESET_VAL;
      rise_q    <= '0;
      fall_q    <= '0;
      changed_q <= 1'b0;
    end else begin
      sync1_q   <= i_sw_raw;
      sync2_q   <= sync1_q;
      presc_q   <= presc_d;
      tick_q    <= tick_c;
      cnt_q     <= cnt_d;
      sw_q      <= sw_d;
      rise_q    <= rise_d;
      fall_q    <= fall_d;
      changed_q <= changed_d;
    end
  end

  assign o_io_sw      = sw_q;
  assign o_sw_rise    = rise_q;
  assign o_sw_fall    = fall_q;
  assign o_sw_changed = changed_q;
  assign o_tick       = tick_q;

endmodule
